shake256_sponge: RTL

- Sponge controller for SHAKE256 (rate 1088 bits / 17 lanes, capacity 512), directly upstream of the Keccak-f[1600] permutation core.
- Absorbs a 64-bit little-endian message word stream and applies SHAKE padding (0x1F ... 0x80).
- Drives keccak_start/state_in and captures state_out on done.
- Exposes the 1088-bit rate portion as squeeze output, with on-demand extra permutations.

---
 rtl/shake256_pkg.sv | 34 +++
 rtl/shake256_pad_mask.sv | 23 ++
 rtl/shake256_sponge.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/shake256_pkg.sv
// Shared constants, FSM encoding and byte-masking helper for the SHAKE256 sponge controller.
package shake256_pkg;

    localparam int RATE_LANES  = 17;
    localparam int RATE_BYTES  = 136;
    localparam int RATE_BITS   = RATE_LANES * 64;
    localparam int STATE_BITS  = 1600;
    localparam logic [7:0] DS_BYTE = 8'h1F;
    localparam logic [7:0] PAD_END = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ABSORB   = 3'd1,
        ST_WAIT_ABS = 3'd2,
        ST_WAIT_PAD = 3'd3,
        ST_WAIT_FIN = 3'd4,
        ST_SQUEEZE  = 3'd5
    } sponge_state_e;

    // Zero every byte at or above nbytes; callers clamp nbytes to 8 first.
    function automatic logic [63:0] keep_bytes(input logic [63:0] data, input logic [3:0] nbytes);
        logic [63:0] m;
        m = 64'd0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < nbytes) begin
                m[8*k +: 8] = 8'hFF;
            end else begin
                m[8*k +: 8] = 8'h00;
            end
        end
        return data & m;
    endfunction

endpackage

// File: rtl/shake256_pad_mask.sv
// Rate-wide XOR mask holding the domain-separation byte at byte pos and the closing pad bit at byte 135.
module shake256_pad_mask
    import shake256_pkg::*;
(
    input  logic [7:0]           pos,
    input  logic                 en,
    output logic [RATE_BITS-1:0] mask
);

    // Byte-wise mask build; when pos is 135 both pad bytes land on the same byte (0x9F).
    always_comb begin
        mask = {RATE_BITS{1'b0}};
        if (en) begin
            for (int k = 0; k < RATE_BYTES; k++) begin
                mask[8*k +: 8] = ((pos == 8'(k)) ? DS_BYTE : 8'h00)
                               ^ ((k == RATE_BYTES - 1) ? PAD_END : 8'h00);
            end
        end else begin
            mask = {RATE_BITS{1'b0}};
        end
    end

endmodule

// File: rtl/shake256_sponge.sv
// SHAKE256 sponge controller: absorbs 64-bit LE words, pads, sequences an external Keccak-f[1600] core
// and presents squeeze blocks on demand.
module shake256_sponge
    import shake256_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [63:0]           in_data,
    input  logic                  in_last,
    input  logic [3:0]            in_bytes,
    output logic                  keccak_start,
    output logic [STATE_BITS-1:0] keccak_state_in,
    input  logic [STATE_BITS-1:0] keccak_state_out,
    input  logic                  keccak_done,
    output logic                  out_valid,
    output logic [RATE_BITS-1:0]  rate_out,
    input  logic                  squeeze_next,
    input  logic                  msg_clear
);

    sponge_state_e         state_r, state_nxt_s;
    logic [STATE_BITS-1:0] s_r, s_nxt_s;
    logic [4:0]            lane_idx_r, lane_nxt_s;
    logic                  start_r, start_nxt_s;
    logic                  out_valid_r;

    logic [3:0]            nbytes_s;
    logic [7:0]            pos_s;
    logic [63:0]           word_s;
    logic [STATE_BITS-1:0] word_shift_s;
    logic [7:0]            pad_pos_s;
    logic                  pad_en_s;
    logic [RATE_BITS-1:0]  pad_mask_s;

    assign nbytes_s     = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    assign pos_s        = {lane_idx_r, 3'b000} + {4'd0, nbytes_s};
    assign word_s       = in_last ? keep_bytes(in_data, nbytes_s) : in_data;
    assign word_shift_s = {{(STATE_BITS-64){1'b0}}, word_s} << {lane_idx_r, 6'd0};

    // The pad-after-full-block case reuses the same mask with the DS byte at byte 0.
    assign pad_pos_s = (state_r == ST_WAIT_PAD) ? 8'd0 : pos_s;
    assign pad_en_s  = (state_r == ST_WAIT_PAD) || ((state_r == ST_ABSORB) && in_last);

    shake256_pad_mask u_pad_mask (
        .pos  (pad_pos_s),
        .en   (pad_en_s),
        .mask (pad_mask_s)
    );

    // Next-state, next-sponge-state and start-request decode.
    always_comb begin
        state_nxt_s = state_r;
        s_nxt_s     = s_r;
        lane_nxt_s  = lane_idx_r;
        start_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_ABSORB;
            end
            ST_ABSORB: begin
                if (msg_clear) begin
                    s_nxt_s    = {STATE_BITS{1'b0}};
                    lane_nxt_s = 5'd0;
                end else if (in_valid) begin
                    if (!in_last) begin
                        s_nxt_s = s_r ^ word_shift_s;
                        if (lane_idx_r == 5'(RATE_LANES - 1)) begin
                            lane_nxt_s  = 5'd0;
                            start_nxt_s = 1'b1;
                            state_nxt_s = ST_WAIT_ABS;
                        end else begin
                            lane_nxt_s = lane_idx_r + 5'd1;
                        end
                    end else if (pos_s < 8'(RATE_BYTES)) begin
                        s_nxt_s     = s_r ^ word_shift_s ^ {{(STATE_BITS-RATE_BITS){1'b0}}, pad_mask_s};
                        lane_nxt_s  = 5'd0;
                        start_nxt_s = 1'b1;
                        state_nxt_s = ST_WAIT_FIN;
                    end else begin
                        s_nxt_s     = s_r ^ word_shift_s;
                        lane_nxt_s  = 5'd0;
                        start_nxt_s = 1'b1;
                        state_nxt_s = ST_WAIT_PAD;
                    end
                end else begin
                    state_nxt_s = ST_ABSORB;
                end
            end
            ST_WAIT_ABS: begin
                if (keccak_done) begin
                    s_nxt_s     = keccak_state_out;
                    state_nxt_s = ST_ABSORB;
                end else begin
                    state_nxt_s = ST_WAIT_ABS;
                end
            end
            ST_WAIT_PAD: begin
                if (keccak_done) begin
                    s_nxt_s     = keccak_state_out ^ {{(STATE_BITS-RATE_BITS){1'b0}}, pad_mask_s};
                    start_nxt_s = 1'b1;
                    state_nxt_s = ST_WAIT_FIN;
                end else begin
                    state_nxt_s = ST_WAIT_PAD;
                end
            end
            ST_WAIT_FIN: begin
                if (keccak_done) begin
                    s_nxt_s     = keccak_state_out;
                    state_nxt_s = ST_SQUEEZE;
                end else begin
                    state_nxt_s = ST_WAIT_FIN;
                end
            end
            ST_SQUEEZE: begin
                if (msg_clear) begin
                    s_nxt_s     = {STATE_BITS{1'b0}};
                    lane_nxt_s  = 5'd0;
                    state_nxt_s = ST_ABSORB;
                end else if (squeeze_next) begin
                    start_nxt_s = 1'b1;
                    state_nxt_s = ST_WAIT_FIN;
                end else begin
                    state_nxt_s = ST_SQUEEZE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, sponge register and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            s_r         <= {STATE_BITS{1'b0}};
            lane_idx_r  <= 5'd0;
            start_r     <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            s_r         <= s_nxt_s;
            lane_idx_r  <= lane_nxt_s;
            start_r     <= start_nxt_s;
            out_valid_r <= (state_nxt_s == ST_SQUEEZE);
        end
    end

    assign in_ready        = (state_r == ST_ABSORB);
    assign keccak_start    = start_r;
    assign keccak_state_in = s_r;
    assign rate_out        = s_r[RATE_BITS-1:0];
    assign out_valid       = out_valid_r;

endmodule
